// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: ownership state encoding,
// default widths and a counter-width helper.
package dm_arbiter_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } arb_state_e;

  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_LIM = 4;
  localparam int DEF_BURST_MAX  = 8;

  // Bits needed to count 0..lim-1, never less than one bit.
  function automatic int cnt_width(input int lim);
    return (lim > 1) ? $clog2(lim) : 1;
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; flags when it sits at LIMIT-1.
module arb_sat_counter
  import dm_arbiter_pkg::*;
#(
  parameter int LIMIT = 4,
  parameter int WIDTH = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign at_limit = (count_q == WIDTH'(LIMIT - 1));

  // Clear dominates increment; the count holds once it reaches the limit.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_limit) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the CPU (default owner) and a DMA
// master that steals idle slots and takes ownership after being starved.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_LIM = DEF_STARVE_LIM,
  parameter int BURST_MAX  = DEF_BURST_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_owner,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  arb_state_e state_q;
  arb_state_e state_d;

  logic wait_inc;
  logic wait_clr;
  logic wait_at_lim;
  logic burst_inc;
  logic burst_clr;
  logic burst_at_lim;
  logic cpu_go;

  // In OWN_CPU the stall is constant zero, so no dma_* input reaches cpu_stall.
  always_comb begin
    dma_gnt   = 1'b0;
    cpu_stall = 1'b0;
    if (state_q == OWN_CPU) begin
      dma_gnt = dma_req & ~cpu_req;
    end else begin
      dma_gnt   = dma_req;
      cpu_stall = cpu_req;
    end
  end

  assign cpu_go    = cpu_req & ~cpu_stall & ~dma_gnt;
  assign mem_we    = dma_gnt ? dma_we : (cpu_go & cpu_we);
  assign mem_addr  = dma_gnt ? dma_addr : cpu_addr;
  assign mem_din   = dma_gnt ? dma_wdata : cpu_wdata;
  assign cpu_rdata = mem_dout;
  assign dma_rdata = mem_dout;
  assign dma_owner = (state_q == OWN_DMA);

  always_comb begin
    state_d   = state_q;
    wait_inc  = 1'b0;
    wait_clr  = 1'b0;
    burst_inc = 1'b0;
    burst_clr = 1'b0;
    if (state_q == OWN_CPU) begin
      burst_clr = 1'b1;
      if (dma_req && !dma_gnt) begin
        if (wait_at_lim) begin
          state_d  = OWN_DMA;
          wait_clr = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end else begin
        wait_clr = 1'b1;
      end
    end else begin
      wait_clr = 1'b1;
      // Only grants that actually hold the CPU off count toward the burst cap.
      if (!dma_req) begin
        state_d   = OWN_CPU;
        burst_clr = 1'b1;
      end else if (cpu_req) begin
        if (burst_at_lim) begin
          state_d   = OWN_CPU;
          burst_clr = 1'b1;
        end else begin
          burst_inc = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OWN_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  arb_sat_counter #(.LIMIT(STARVE_LIM)) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (wait_inc),
    .clr      (wait_clr),
    .at_limit (wait_at_lim)
  );

  arb_sat_counter #(.LIMIT(BURST_MAX)) u_burst_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (burst_inc),
    .clr      (burst_clr),
    .at_limit (burst_at_lim)
  );

endmodule
